// File: rtl/gate_sweep_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// gate_sweep_ctrl_pkg
//   Shared definitions for the gate sweep controllers:
//     - state_t        : sweep FSM states (binary encoded)
//     - GRAY_TABLE     : input vectors in Gray order, entry k at bits [2k+1:2k]
//     - EXP_*          : expected truth tables, bit index = {x,y}
//     - gray_vec()     : looks up vector k of the Gray sequence
//     - expected_for() : expected truth table for a gate kind
//   No ports; imported by the interface, the timer and the top.
// ---------------------------------------------------------------------------
package gate_sweep_ctrl_pkg;

  // Counter width of the settle timer; SETTLE_CYCLES must fit in it.
  localparam int unsigned SETTLE_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Vector order 00, 01, 11, 10: one input toggles per step, so a glitch
  // on the gate output can only come from the single changing input.
  localparam logic [7:0] GRAY_TABLE = {2'b10, 2'b11, 2'b01, 2'b00};

  // Truth tables indexed by {x,y}: bit 0 = 00, bit 1 = 01, bit 2 = 10, bit 3 = 11.
  localparam logic [3:0] EXP_OR   = 4'b1110;
  localparam logic [3:0] EXP_AND  = 4'b1000;
  localparam logic [3:0] EXP_XOR  = 4'b0110;
  localparam logic [3:0] EXP_NAND = 4'b0111;

  typedef enum logic [1:0] {
    GATE_OR   = 2'd0,
    GATE_AND  = 2'd1,
    GATE_XOR  = 2'd2,
    GATE_NAND = 2'd3
  } gate_kind_t;

  function automatic logic [1:0] gray_vec(input logic [1:0] idx);
    logic [7:0] table_bits;
    table_bits = GRAY_TABLE;
    return table_bits[{idx, 1'b0} +: 2];
  endfunction

  function automatic logic [3:0] expected_for(input gate_kind_t kind);
    logic [3:0] result;
    case (kind)
      GATE_OR:   result = EXP_OR;
      GATE_AND:  result = EXP_AND;
      GATE_XOR:  result = EXP_XOR;
      GATE_NAND: result = EXP_NAND;
      default:   result = EXP_OR;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// gate_sweep_ctrl_if
//   Bundles the host handshake and the gate-under-test connections of one
//   sweeper.
//     start       host -> sweeper  request a sweep
//     busy        sweeper -> host  sweep in progress
//     done        sweeper -> host  one-cycle result-valid pulse
//     truth_table sweeper -> host  captured gate outputs, bit {x,y}
//     mismatch    sweeper -> host  truth_table XOR expected
//     pass        sweeper -> host  mismatch == 0
//     x, y        sweeper -> gate  gate inputs
//     z           gate -> sweeper  gate output
//   slave  : the sweeper side
//   master : the environment side (host plus gate)
// ---------------------------------------------------------------------------
interface gate_sweep_ctrl_if;

  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] truth_table;
  logic [3:0] mismatch;
  logic       pass;
  logic       x;
  logic       y;
  logic       z;

  modport slave (
    input  start,
    input  z,
    output busy,
    output done,
    output truth_table,
    output mismatch,
    output pass,
    output x,
    output y
  );

  modport master (
    output start,
    output z,
    input  busy,
    input  done,
    input  truth_table,
    input  mismatch,
    input  pass,
    input  x,
    input  y
  );

endinterface

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer
//   Loadable down-counter used to hold each vector for a fixed number of
//   cycles before sampling.
//     clk        in   rising-edge clock
//     reset      in   synchronous, active-high; clears the count
//     load       in   load load_value (takes priority over en)
//     en         in   decrement by one; holds at zero
//     load_value in   WIDTH-bit reload value
//     last       out  count is zero (final cycle of the window)
//   Loading N gives N+1 cycles before last is seen with en held high.
// ---------------------------------------------------------------------------
module settle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic             last
);

  logic [WIDTH-1:0] count;

  // Load wins over decrement; the count saturates at zero so an
  // over-long enable can never wrap into a huge window.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// gate_sweep_ctrl
//   Clocked, self-checking sweep of one 2-input combinational gate. Drives
//   the four input vectors in Gray order, holds each for SETTLE_CYCLES
//   cycles, samples z one cycle later, builds the truth table and compares
//   it with EXPECTED.
//   Parameters:
//     SETTLE_CYCLES  cycles each vector is held before sampling (1..255)
//     EXPECTED       expected truth table, bit index {x,y} (default OR)
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   synchronous, active-high; abandons any sweep in progress
//     bus    slave side of gate_sweep_ctrl_if (host handshake + gate pins)
// ---------------------------------------------------------------------------
module gate_sweep_ctrl
  import gate_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECTED      = EXP_OR
) (
  input  logic               clk,
  input  logic               reset,
  gate_sweep_ctrl_if.slave   bus
);

  // The timer counts down to zero, so SETTLE_CYCLES cycles of hold means
  // loading one less than that.
  localparam logic [SETTLE_WIDTH-1:0] SETTLE_LOAD = SETTLE_WIDTH'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     next_state;
  logic [1:0] idx;
  logic [1:0] vec;
  logic [3:0] truth_table_q;
  logic [3:0] table_with_z;
  logic [3:0] mismatch_q;
  logic       pass_q;
  logic       timer_load;
  logic       timer_en;
  logic       timer_last;

  settle_timer #(
    .WIDTH (SETTLE_WIDTH)
  ) u_settle_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .en         (timer_en),
    .load_value (SETTLE_LOAD),
    .last       (timer_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. start only matters in IDLE, so a start seen while
  // busy or during DONE is simply dropped rather than queued.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (bus.start)  next_state = ST_SETTLE;
      ST_SETTLE: if (timer_last) next_state = ST_SAMPLE;
      ST_SAMPLE: next_state = (idx == 2'd3) ? ST_DONE : ST_SETTLE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Output and control decode. The vector stays on the pins through
  // SAMPLE so z is captured against the same inputs it settled on.
  always_comb begin
    vec        = 2'b00;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        timer_load = bus.start;
      end
      ST_SETTLE: begin
        vec      = gray_vec(idx);
        timer_en = !timer_last;
      end
      ST_SAMPLE: begin
        vec        = gray_vec(idx);
        timer_load = (idx != 2'd3);
      end
      default: begin
        vec = 2'b00;
      end
    endcase
  end

  assign bus.x           = vec[1];
  assign bus.y           = vec[0];
  assign bus.busy        = (state != ST_IDLE);
  assign bus.done        = (state == ST_DONE);
  assign bus.truth_table = truth_table_q;
  assign bus.mismatch    = mismatch_q;
  assign bus.pass        = pass_q;

  // Truth table including the bit being sampled this cycle; used so the
  // verdict can be registered together with the final sample and is
  // already valid while done is high.
  always_comb begin
    table_with_z      = truth_table_q;
    table_with_z[vec] = bus.z;
  end

  // Result datapath: clear on an accepted start, capture z in SAMPLE,
  // and latch the verdict alongside the last sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx           <= 2'd0;
      truth_table_q <= 4'b0000;
      mismatch_q    <= 4'b0000;
      pass_q        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            idx           <= 2'd0;
            truth_table_q <= 4'b0000;
            mismatch_q    <= 4'b0000;
            pass_q        <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          truth_table_q <= table_with_z;
          if (idx == 2'd3) begin
            mismatch_q <= table_with_z ^ EXPECTED;
            pass_q     <= (table_with_z == EXPECTED);
          end else begin
            idx <= idx + 2'd1;
          end
        end
        default: begin
          idx <= idx;
        end
      endcase
    end
  end

endmodule
